// File: rtl/imem_load_sequencer.sv
// Boot-time loader: pulls a program image word-by-word from an instruction source
// over a req/valid handshake and writes it into the instruction store from base_addr.
module imem_load_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              src_req,
  output logic [ADDR_W:0]   src_idx,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W:0]   words_loaded,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TOP  = '1;
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   data_q;
  logic                ovf_q;
  logic                last_word;
  logic                at_top;

  assign last_word = ((count_q + CNT_ONE) == len_q);
  assign at_top    = (pc_q == PC_TOP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A completed image takes priority over hitting the top of the store,
  // so an image that exactly fills the store is not flagged as overflow.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (length == '0) ? DONE : REQ;
      REQ:   if (src_valid) state_next = WRITE;
      WRITE: state_next = (last_word || at_top) ? DONE : REQ;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pc_q    <= base_addr;
            len_q   <= length;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        REQ: begin
          if (src_valid) data_q <= src_data;
        end
        WRITE: begin
          pc_q    <= pc_q + PC_ONE;
          count_q <= count_q + CNT_ONE;
          if (!last_word && at_top) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // src_idx is forced to zero outside REQ so every output reads 0 after reset.
  assign src_req      = (state == REQ);
  assign src_idx      = (state == REQ) ? count_q : '0;
  assign mem_we       = (state == WRITE);
  assign mem_addr     = pc_q;
  assign mem_wdata    = data_q;
  assign load_pc      = pc_q;
  assign words_loaded = count_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Randomised self-checking bench for imem_load_sequencer; expected writes come from
// a min(length, space-left) model of the load, not from the DUT's state machine.
module tb_imem_load_sequencer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              src_req;
  logic [ADDR_W:0]   src_idx;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] load_pc;
  logic [ADDR_W:0]   words_loaded;
  logic              busy;
  logic              done;
  logic              overflow;

  imem_load_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .src_req(src_req), .src_idx(src_idx), .src_valid(src_valid), .src_data(src_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_pc(load_pc),
    .words_loaded(words_loaded), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total;
  int passed;

  logic [DATA_W-1:0] src_words [0:DEPTH];
  int                wait_plan [$];

  int                wr_addr [$];
  logic [DATA_W-1:0] wr_data [$];
  int                wr_cyc  [$];
  int   done_count, done_cyc, idle_cyc, req_cycles, idx_errors, first_req_idx, total_wait;
  int   obs_words, obs_pc;
  logic obs_ovf, obs_ovf_idle, timed_out, abort_nonzero;

  function automatic int exp_count(input int base, input int len);
    return (len < DEPTH - base) ? len : DEPTH - base;
  endfunction

  function automatic void fill_words(input int len, input bit seq);
    for (int i = 0; i < len; i++)
      src_words[i] = seq ? DATA_W'(32'hA0 + i) : $urandom;
  endfunction

  // Drives one load (source + optional noise), records what the DUT did.
  task automatic run_load(input int base, input int len, input int max_wait,
                          input bit inject, input int abort_after);
    int  cyc;
    int  w_left;
    bit  got_done;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_count = 0; done_cyc = -1; idle_cyc = -1; req_cycles = 0; idx_errors = 0;
    first_req_idx = -1; total_wait = 0; obs_words = -1; obs_pc = -1;
    obs_ovf = 1'bx; obs_ovf_idle = 1'bx; abort_nonzero = 1'b1; timed_out = 1'b1;
    w_left = -1; got_done = 1'b0;
    base_addr = ADDR_W'(base);
    length    = (ADDR_W + 1)'(len);
    start     = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc < BUDGET) begin
      start = 1'b0; src_valid = 1'b0; src_data = $urandom;
      base_addr = ADDR_W'($urandom); length = (ADDR_W + 1)'($urandom);
      if (mem_we) begin
        wr_addr.push_back(int'(mem_addr)); wr_data.push_back(mem_wdata); wr_cyc.push_back(cyc);
      end
      if (src_req) begin
        req_cycles++;
        if (first_req_idx < 0) first_req_idx = int'(src_idx);
        if (int'(src_idx) != wr_addr.size()) idx_errors++;
        if (w_left < 0) begin
          if (wait_plan.size() > 0) w_left = wait_plan.pop_front();
          else w_left = $urandom_range(max_wait, 0);
          total_wait += w_left;
        end
        if (w_left == 0) begin
          src_valid = 1'b1;
          src_data  = (int'(src_idx) <= DEPTH) ? src_words[src_idx] : '0;
          w_left    = -1;
        end else w_left--;
      end
      if (done) begin
        done_count++; done_cyc = cyc; got_done = 1'b1;
        obs_ovf = overflow; obs_words = int'(words_loaded); obs_pc = int'(load_pc);
      end else if (got_done && !busy) begin
        idle_cyc = cyc; obs_ovf_idle = overflow; timed_out = 1'b0;
        break;
      end
      if (inject && busy) begin
        if (!src_req) src_valid = 1'b1;
        start = 1'($urandom_range(1, 0));
      end
      if (abort_after > 0 && mem_we && wr_addr.size() == abort_after) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        abort_nonzero = |{src_req, src_idx, mem_we, mem_addr, mem_wdata, load_pc,
                          words_loaded, busy, done, overflow};
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; src_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = 64'({src_req, src_idx, mem_we, mem_addr, mem_wdata, load_pc, words_loaded,
                busy, done, overflow});
    total++;
    if (outs !== 64'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int bad;
    fill_words(5, 1'b1);
    wait_plan = '{0, 0, 0, 0, 0};
    run_load(32'h11, 5, 0, 1'b0, 0);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 5; i++)
      if (wr_addr[i] != 32'h11 + i || wr_data[i] !== DATA_W'(32'hA0 + i) || wr_cyc[i] != 2 * i + 2)
        bad++;
    total++; if (timed_out !== 1'b0) $display("[TB] FAIL basic_timeout: got %b expected 0", timed_out); else passed++;
    total++; if (wr_addr.size() != 5) $display("[TB] FAIL basic_writes: got %0d expected 5", wr_addr.size()); else passed++;
    total++; if (bad != 0) $display("[TB] FAIL basic_addr_data_cycle: got %0d bad writes expected 0", bad); else passed++;
    total++; if (done_cyc != 11) $display("[TB] FAIL basic_done_cycle: got %0d expected 11", done_cyc); else passed++;
    total++; if (idle_cyc != 12) $display("[TB] FAIL basic_idle_cycle: got %0d expected 12", idle_cyc); else passed++;
    total++; if (obs_words != 5) $display("[TB] FAIL basic_words_loaded: got %0d expected 5", obs_words); else passed++;
    total++; if (obs_pc != 32'h16) $display("[TB] FAIL basic_load_pc: got %0h expected 16", obs_pc); else passed++;
    total++; if (idx_errors != 0) $display("[TB] FAIL basic_src_idx: got %0d bad expected 0", idx_errors); else passed++;
  endtask

  task automatic test_wait_states();
    int bad;
    fill_words(3, 1'b0);
    wait_plan = '{0, 3, 1};
    run_load(32'h200, 3, 0, 1'b0, 0);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 3; i++)
      if (wr_addr[i] != 32'h200 + i || wr_data[i] !== src_words[i]) bad++;
    total++; if (wr_addr.size() != 3 || bad != 0) $display("[TB] FAIL wait_writes: got %0d writes %0d bad expected 3 writes 0 bad", wr_addr.size(), bad); else passed++;
    total++; if (req_cycles != 7) $display("[TB] FAIL wait_req_held: got %0d req cycles expected 7", req_cycles); else passed++;
    total++; if (idx_errors != 0) $display("[TB] FAIL wait_src_idx: got %0d bad expected 0", idx_errors); else passed++;
    total++; if (done_count != 1 || done_cyc != 11) $display("[TB] FAIL wait_done: got %0d pulses at %0d expected 1 at 11", done_count, done_cyc); else passed++;
  endtask

  task automatic test_overflow();
    fill_words(4, 1'b0);
    run_load(32'h3FE, 4, 1, 1'b0, 0);
    total++; if (wr_addr.size() != 2 || (wr_addr.size() == 2 && (wr_addr[0] != 32'h3FE || wr_addr[1] != 32'h3FF)))
      $display("[TB] FAIL ovf_writes: got %0d writes expected 2 at 3fe,3ff", wr_addr.size()); else passed++;
    total++; if (obs_ovf !== 1'b1 || done_count != 1) $display("[TB] FAIL ovf_flag_done: got ovf=%b done=%0d expected 1/1", obs_ovf, done_count); else passed++;
    total++; if (obs_words != 2) $display("[TB] FAIL ovf_words_loaded: got %0d expected 2", obs_words); else passed++;
    total++; if (obs_ovf_idle !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", obs_ovf_idle); else passed++;
    fill_words(1, 1'b0);
    run_load(0, 1, 0, 1'b0, 0);
    total++; if (obs_ovf !== 1'b0) $display("[TB] FAIL ovf_cleared_by_start: got %b expected 0", obs_ovf); else passed++;
  endtask

  task automatic test_zero_length();
    run_load(32'h55, 0, 0, 1'b0, 0);
    total++; if (done_cyc != 1 || done_count != 1) $display("[TB] FAIL zero_done: got %0d pulses at %0d expected 1 at 1", done_count, done_cyc); else passed++;
    total++; if (req_cycles != 0 || wr_addr.size() != 0) $display("[TB] FAIL zero_no_activity: got %0d req %0d writes expected 0/0", req_cycles, wr_addr.size()); else passed++;
  endtask

  task automatic test_abort_reset();
    fill_words(5, 1'b0);
    run_load(32'h40, 5, 1, 1'b0, 2);
    total++; if (abort_nonzero !== 1'b0 || timed_out !== 1'b0) $display("[TB] FAIL abort_outputs_zero: got %b expected 0", abort_nonzero); else passed++;
    fill_words(3, 1'b0);
    run_load(32'h80, 3, 1, 1'b0, 0);
    total++; if (first_req_idx != 0) $display("[TB] FAIL abort_restart_idx: got %0d expected 0", first_req_idx); else passed++;
    total++; if (wr_addr.size() != 3 || (wr_addr.size() == 3 && (wr_addr[0] != 32'h80 || wr_data[2] !== src_words[2])))
      $display("[TB] FAIL abort_restart_writes: got %0d writes expected 3", wr_addr.size()); else passed++;
  endtask

  task automatic test_ignored_inputs();
    int bad;
    fill_words(6, 1'b0);
    run_load(32'h100, 6, 2, 1'b1, 0);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 6; i++)
      if (wr_addr[i] != 32'h100 + i || wr_data[i] !== src_words[i]) bad++;
    total++; if (wr_addr.size() != 6 || bad != 0) $display("[TB] FAIL noise_writes: got %0d writes %0d bad expected 6/0", wr_addr.size(), bad); else passed++;
    total++; if (obs_words != 6 || done_count != 1) $display("[TB] FAIL noise_count: got %0d words %0d done expected 6/1", obs_words, done_count); else passed++;
  endtask

  task automatic test_random();
    int base, len, n, bad;
    for (int k = 0; k < 8; k++) begin
      base = (k % 2 == 0) ? $urandom_range(DEPTH - 1, 0) : DEPTH - $urandom_range(8, 1);
      len  = $urandom_range(12, 1);
      n    = exp_count(base, len);
      fill_words(len, 1'b0);
      run_load(base, len, 2, 1'b0, 0);
      bad = 0;
      for (int i = 0; i < wr_addr.size() && i < n; i++)
        if (wr_addr[i] != base + i || wr_data[i] !== src_words[i]) bad++;
      total++; if (wr_addr.size() != n || bad != 0) $display("[TB] FAIL rand%0d_writes: got %0d writes %0d bad expected %0d/0", k, wr_addr.size(), bad, n); else passed++;
      total++; if (obs_words != n || obs_pc != (base + n) % DEPTH) $display("[TB] FAIL rand%0d_counters: got words %0d pc %0d expected %0d/%0d", k, obs_words, obs_pc, n, (base + n) % DEPTH); else passed++;
      total++; if (obs_ovf !== 1'(len > DEPTH - base)) $display("[TB] FAIL rand%0d_overflow: got %b expected %b", k, obs_ovf, len > DEPTH - base); else passed++;
      total++; if (done_count != 1 || done_cyc != 2 * n + 1 + total_wait) $display("[TB] FAIL rand%0d_done: got %0d at %0d expected 1 at %0d", k, done_count, done_cyc, 2 * n + 1 + total_wait); else passed++;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; src_valid = 1'b0; src_data = '0;
    test_reset();
    test_basic();
    test_wait_states();
    test_overflow();
    test_zero_length();
    test_abort_reset();
    test_ignored_inputs();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
